// File: rtl/axil_ram_slave.sv
// axil_ram_slave
//   AXI4-Lite slave backed by a word-organised RAM with byte strobes.
//   Write and read channels run independent FSMs. Every output is registered.
//   Each access is range- and alignment-checked: DECERR when out of range,
//   SLVERR when misaligned, OKAY otherwise.
//
// Ports
//   clk, reset (asynchronous, active-low)
//   Write address : awvalid, awready, awaddress[31:0], awprot[2:0] (ignored)
//   Write data    : wvalid, wready, wdata[31:0], wstrb[3:0]
//   Write resp    : bvalid, bready, bresp[1:0]
//   Read address  : arvalid, arready, araddress[31:0], arprot[2:0] (ignored)
//   Read data     : rvalid, rready, rdata[31:0], rresp[1:0]
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words; a power of two and at least 2.
//   BASE_ADDR   : byte address of word 0; aligned to DEPTH_WORDS*4.
//   READ_WAIT   : extra cycles between AR acceptance and RVALID (0..15).
module axil_ram_slave #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned READ_WAIT   = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddress,
    input  logic [2:0]  awprot,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddress,
    input  logic [2:0]  arprot,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp
);
    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  CNT_LOAD = (READ_WAIT == 0) ? 4'd0 : 4'(READ_WAIT - 1);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic       {W_IDLE, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;

    // The subtraction wraps modulo 2^32, so addresses below BASE_ADDR
    // become large offsets and decode as DECERR.
    function automatic logic [1:0] decode(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        if ({1'b0, off} >= SPAN)   return RESP_DECERR;
        if (addr[1:0] != 2'b00)    return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return off[IDX_W+1:2];
    endfunction

    logic [31:0] mem_q [DEPTH_WORDS];

    w_state_t    w_state_q;
    logic        awready_q, wready_q, bvalid_q;
    logic [1:0]  bresp_q;
    logic        aw_have_q, w_have_q;
    logic [31:0] awaddr_q, wdata_q;
    logic [3:0]  wstrb_q;

    r_state_t    r_state_q;
    logic        arready_q, rvalid_q;
    logic [1:0]  rresp_q;
    logic [31:0] rdata_q, araddr_q;
    logic [3:0]  cnt_q;

    logic        aw_hs, w_hs, ar_hs, commit;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
    logic [3:0]  wr_strb;
    logic [1:0]  wr_resp, rd_resp;

    wire unused_prot = ^{awprot, arprot};

    // A beat arriving this cycle is bypassed straight into the commit, so
    // AW and W in the same cycle produce bvalid on the next cycle.
    always_comb begin
        aw_hs   = awvalid && awready_q;
        w_hs    = wvalid && wready_q;
        ar_hs   = arvalid && arready_q;
        wr_addr = aw_hs ? awaddress : awaddr_q;
        wr_data = w_hs ? wdata : wdata_q;
        wr_strb = w_hs ? wstrb : wstrb_q;
        wr_resp = decode(wr_addr);
        commit  = (w_state_q == W_IDLE) && (aw_hs || aw_have_q) && (w_hs || w_have_q);
        rd_addr = (r_state_q == R_IDLE) ? araddress : araddr_q;
        rd_resp = decode(rd_addr);
        rd_data = (rd_resp == RESP_OKAY) ? mem_q[word_idx(rd_addr)] : 32'd0;
    end

    // RAM is never reset. Reads sample mem_q on the same edge, so they see
    // the pre-write contents of a word being written that cycle.
    always_ff @(posedge clk) begin
        if (commit && wr_resp == RESP_OKAY) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) mem_q[word_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_have_q <= 1'b0;
            w_have_q  <= 1'b0;
            awaddr_q  <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        awaddr_q  <= awaddress;
                        aw_have_q <= 1'b1;
                        awready_q <= 1'b0;
                    end else if (!aw_have_q) begin
                        awready_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wdata_q  <= wdata;
                        wstrb_q  <= wstrb;
                        w_have_q <= 1'b1;
                        wready_q <= 1'b0;
                    end else if (!w_have_q) begin
                        wready_q <= 1'b1;
                    end
                    if (commit) begin
                        aw_have_q <= 1'b0;
                        w_have_q  <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b0;
                        bresp_q   <= wr_resp;
                        bvalid_q  <= 1'b1;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= 32'd0;
            araddr_q  <= 32'd0;
            cnt_q     <= 4'd0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        araddr_q  <= araddress;
                        arready_q <= 1'b0;
                        if (READ_WAIT == 0) begin
                            rdata_q   <= rd_data;
                            rresp_q   <= rd_resp;
                            rvalid_q  <= 1'b1;
                            r_state_q <= R_RESP;
                        end else begin
                            cnt_q     <= CNT_LOAD;
                            r_state_q <= R_WAIT;
                        end
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                // Counter is loaded with READ_WAIT-1 so RVALID lands
                // READ_WAIT+1 cycles after the AR handshake.
                R_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rdata_q   <= rd_data;
                        rresp_q   <= rd_resp;
                        rvalid_q  <= 1'b1;
                        r_state_q <= R_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axil_ram_slave.sv
module tb_axil_ram_slave;
    logic        clk = 1'b0;
    logic        reset;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] awaddress, wdata, araddress;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    // Second instance with READ_WAIT=3 shares the write channel inputs and
    // read address, but has its own arvalid/rready.
    logic        arvalid3, rready3;
    logic        awready3, wready3, bvalid3, arready3, rvalid3;
    logic [1:0]  bresp3, rresp3;
    logic [31:0] rdata3;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    axil_ram_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .READ_WAIT(0)) u0 (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddress(awaddress), .awprot(3'b000),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddress(araddress), .arprot(3'b000),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
    );

    axil_ram_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .READ_WAIT(3)) u3 (
        .clk(clk), .reset(reset),
        .awvalid(awvalid), .awready(awready3), .awaddress(awaddress), .awprot(3'b000),
        .wvalid(wvalid), .wready(wready3), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid3), .bready(bready), .bresp(bresp3),
        .arvalid(arvalid3), .arready(arready3), .araddress(araddress), .arprot(3'b000),
        .rvalid(rvalid3), .rready(rready3), .rdata(rdata3), .rresp(rresp3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_same(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [1:0] exp_resp,
                              input string tag);
        awvalid = 1'b1; awaddress = a; wvalid = 1'b1; wdata = d; wstrb = s; bready = 1'b0;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check({tag, ".bvalid"}, 32'(bvalid), 32'd1);
        check({tag, ".bresp"},  32'(bresp),  32'(exp_resp));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check({tag, ".bdone"},  32'(bvalid),  32'd0);
        check({tag, ".awrdy"},  32'(awready), 32'd1);
    endtask

    task automatic read0(input logic [31:0] a, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input string tag);
        arvalid = 1'b1; araddress = a; rready = 1'b0;
        tick();
        arvalid = 1'b0;
        check({tag, ".rvalid"}, 32'(rvalid), 32'd1);
        check({tag, ".rdata"},  rdata,       exp_data);
        check({tag, ".rresp"},  32'(rresp),  32'(exp_resp));
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check({tag, ".rdone"},  32'(rvalid),  32'd0);
        check({tag, ".arrdy"},  32'(arready), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
        arvalid3 = 1'b0; rready3 = 1'b0;
        awaddress = 32'd0; wdata = 32'd0; araddress = 32'd0; wstrb = 4'd0;

        // Reset state
        tick(); tick();
        check("rst.awready", 32'(awready), 32'd0);
        check("rst.wready",  32'(wready),  32'd0);
        check("rst.arready", 32'(arready), 32'd0);
        check("rst.bvalid",  32'(bvalid),  32'd0);
        check("rst.rvalid",  32'(rvalid),  32'd0);
        check("rst.rdata",   rdata,        32'd0);
        check("rst.resp",    32'({bresp, rresp}), 32'd0);
        check("rst.u3",      32'({awready3, wready3, bvalid3, bresp3, arready3, rvalid3, rresp3}), 32'd0);
        reset = 1'b1;
        tick();
        check("rel.awready", 32'(awready),  32'd1);
        check("rel.wready",  32'(wready),   32'd1);
        check("rel.arready", 32'(arready),  32'd1);
        check("rel.arready3", 32'(arready3), 32'd1);

        // Full write then read back
        write_same(32'h10, 32'hDEADBEEF, 4'hF, 2'b00, "wr10");
        read0(32'h10, 32'hDEADBEEF, 2'b00, "rd10");

        // Partial strobe
        write_same(32'h10, 32'h11223344, 4'b0101, 2'b00, "wr10p");
        read0(32'h10, 32'hDE22BE44, 2'b00, "rd10p");

        // W three cycles ahead of AW, then a stalled B channel
        wvalid = 1'b1; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        tick();
        wvalid = 1'b0;
        check("wfirst.wready", 32'(wready),  32'd0);
        check("wfirst.awrdy",  32'(awready), 32'd1);
        check("wfirst.bvalid", 32'(bvalid),  32'd0);
        tick(); tick();
        check("wfirst.bwait",  32'(bvalid),  32'd0);
        awvalid = 1'b1; awaddress = 32'h20;
        tick();
        awvalid = 1'b0;
        check("wfirst.bvalid1", 32'(bvalid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall.bvalid", 32'(bvalid),  32'd1);
            check("stall.bresp",  32'(bresp),   32'd0);
            check("stall.awrdy",  32'(awready), 32'd0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("stall.bdone", 32'(bvalid),  32'd0);
        check("stall.awrdy1", 32'(awready), 32'd1);
        check("stall.wrdy1",  32'(wready),  32'd1);
        read0(32'h20, 32'hA5A5A5A5, 2'b00, "rd20");

        // Error decode; word 0 seeded so an aliasing write would show
        write_same(32'h0, 32'h01234567, 4'hF, 2'b00, "wr0");
        write_same(32'h1000, 32'hFFFFFFFF, 4'hF, 2'b11, "wrdec");
        read0(32'h0, 32'h01234567, 2'b00, "rd0");
        read0(32'h2, 32'h0, 2'b10, "rdslv");
        read0(32'hFFFFFFFC, 32'h0, 2'b11, "rddec");

        // Read-before-write on the same word in the same cycle
        write_same(32'h30, 32'h11111111, 4'hF, 2'b00, "wr30");
        awvalid = 1'b1; awaddress = 32'h30; wvalid = 1'b1; wdata = 32'h22222222; wstrb = 4'hF;
        arvalid = 1'b1; araddress = 32'h30;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("rbw.rdata",  rdata,        32'h11111111);
        check("rbw.bvalid", 32'(bvalid),  32'd1);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        read0(32'h30, 32'h22222222, 2'b00, "rd30");

        // READ_WAIT=3 instance: rvalid four cycles after the handshake
        arvalid3 = 1'b1; araddress = 32'h10;
        tick();
        arvalid3 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check("rw3.rvalid0", 32'(rvalid3),  32'd0);
            check("rw3.arrdy0",  32'(arready3), 32'd0);
            tick();
        end
        check("rw3.rvalid", 32'(rvalid3), 32'd1);
        check("rw3.rdata",  rdata3,       32'hDE22BE44);
        check("rw3.rresp",  32'(rresp3),  32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rw3.hold.rvalid", 32'(rvalid3),  32'd1);
            check("rw3.hold.rdata",  rdata3,        32'hDE22BE44);
            check("rw3.hold.arrdy",  32'(arready3), 32'd0);
        end
        rready3 = 1'b1;
        tick();
        rready3 = 1'b0;
        check("rw3.rdone", 32'(rvalid3),  32'd0);
        check("rw3.arrdy", 32'(arready3), 32'd1);

        // Reset while a read waits and a write holds only AW
        awvalid = 1'b1; awaddress = 32'h40; arvalid3 = 1'b1; araddress = 32'h10;
        tick();
        awvalid = 1'b0; arvalid3 = 1'b0;
        tick();
        check("mid.awrdy", 32'(awready), 32'd0);
        #2;
        reset = 1'b0;
        #1;
        check("mid.u0", 32'({awready, wready, arready, bvalid, rvalid}), 32'd0);
        check("mid.u3", 32'({arready3, rvalid3}), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("post.readies", 32'({awready, wready, arready, arready3}), 32'hF);
        check("post.valids",  32'({bvalid, rvalid, rvalid3}), 32'd0);
        wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        tick();
        wvalid = 1'b0;
        tick(); tick(); tick();
        check("post.nostaleb", 32'(bvalid),  32'd0);
        check("post.nostaler", 32'(rvalid3), 32'd0);
        awvalid = 1'b1; awaddress = 32'h44;
        tick();
        awvalid = 1'b0;
        check("post.bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        read0(32'h10, 32'hDE22BE44, 2'b00, "post.rd10");
        read0(32'h44, 32'hCAFEF00D, 2'b00, "post.rd44");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
